// File: rtl/matmult_pkg.sv
// Shared types and default sizing for the sequential NxN matrix multiplier.
package matmult_pkg;

  localparam int N_DEF  = 2;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Width of the k index; a 1x1 matrix still needs a 1-bit counter.
  function automatic int kw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmult_mac_lane.sv
// One C element: DW x DW multiply extended to AW and accumulated in place.
// MATMULT_SIGNED_EN selects two's-complement operands; otherwise unsigned.
module matmult_mac_lane #(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [AW-1:0] o_acc
);

  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   w_ext;
  logic [AW-1:0]   r_acc;

`ifdef MATMULT_SIGNED_EN
  assign w_prod = {{DW{i_a[DW-1]}}, i_a} * {{DW{i_b[DW-1]}}, i_b};

  always_comb begin
    w_ext             = {AW{w_prod[2*DW-1]}};
    w_ext[2*DW-1:0]   = w_prod;
  end
`else
  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  always_comb begin
    w_ext             = '0;
    w_ext[2*DW-1:0]   = w_prod;
  end
`endif

  // Sums wrap modulo 2^AW by design.
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (i_en)    r_acc <= r_acc + w_ext;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/matmult_seq.sv
// Sequential NxN matrix multiply: one k-step per cycle across all N*N lanes.
// Optional MATMULT_SIGNED_EN makes the operands two's-complement.
module matmult_seq
  import matmult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              acc_en,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] c_flat,
  output logic              busy
);

  localparam int KW = kw(N);

  if (AW < 2*DW) begin : g_bad_aw
    $error("matmult_seq: AW must be at least 2*DW");
  end
  if (N < 1 || N > 8) begin : g_bad_n
    $error("matmult_seq: N must be in 1..8");
  end

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k;
  logic [DW-1:0] r_a [N][N];
  logic [DW-1:0] r_b [N][N];
  logic          w_accept, w_last, w_clr;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_COMPUTE);
  assign out_valid = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_k == KW'(N-1));
    case (r_state)
      S_IDLE:    if (in_valid) begin
                   w_accept    = 1'b1;
                   w_state_nxt = S_COMPUTE;
                 end
      S_COMPUTE: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:    if (out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operands are captured once at accept; the input bus is free afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
    end else if (w_accept) begin
      r_k <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= a_flat[(i*N+j)*DW +: DW];
          r_b[i][j] <= b_flat[(i*N+j)*DW +: DW];
        end
    end else if (busy) begin
      r_k <= w_last ? '0 : r_k + 1'b1;
    end
  end

  // acc_en only matters at accept: it decides whether C starts from zero.
  assign w_clr = w_accept && !acc_en;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmult_mac_lane #(.DW(DW), .AW(AW)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (busy),
        .i_a   (r_a[i][r_k]),
        .i_b   (r_b[r_k][j]),
        .o_acc (c_flat[(i*N+j)*AW +: AW])
      );
    end
  end

endmodule

// File: tb/tb_matmult_seq.sv
// Scoreboard bench for matmult_seq: directed jobs plus randomized jobs vs a behavioural model.
module tb_matmult_seq;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int CW = N*N*AW;
  localparam int IW = N*N*DW;

  logic          clk = 1'b0;
  logic          rst, in_valid, acc_en, out_ready;
  logic [IW-1:0] a_flat, b_flat;
  logic          in_ready, out_valid, busy;
  logic [CW-1:0] c_flat;

  matmult_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc_en(acc_en), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .c_flat(c_flat), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int            n_chk = 0, n_pass = 0;
  logic [CW-1:0] exp_q[$];
  int            acc_q[$];
  logic [CW-1:0] held = '0;
  bit            rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, expv);
  endtask

  task automatic chki(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, expv);
  endtask

  function automatic logic [IW-1:0] pk(input int e00, e01, e10, e11);
    return {16'(e11), 16'(e10), 16'(e01), 16'(e00)};
  endfunction

  function automatic logic [CW-1:0] pc(input int e00, e01, e10, e11);
    return {32'(e11), 32'(e10), 32'(e01), 32'(e00)};
  endfunction

  function automatic longint elem(input logic [DW-1:0] x);
`ifdef MATMULT_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  // Plain matrix arithmetic: C = (acc ? H : 0) + A*B, each element mod 2^AW.
  function automatic logic [CW-1:0] model(input logic [IW-1:0] a, b, input bit acc,
                                          input logic [CW-1:0] h);
    logic [CW-1:0] r;
    longint        s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = acc ? longint'(h[(i*N+j)*AW +: AW]) : 64'sd0;
        for (int k = 0; k < N; k++)
          s += elem(a[(i*N+k)*DW +: DW]) * elem(b[(k*N+j)*DW +: DW]);
        r[(i*N+j)*AW +: AW] = s[AW-1:0];
      end
    return r;
  endfunction

  // Monitor: latency on each rising out_valid, result on each handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_ov) begin
      if (acc_q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_out_valid: got out_valid=1 want no pending job (cycle %0d)", cyc);
      end else chki("latency", cyc - acc_q[0], N);
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got %h want nothing", c_flat);
      end else begin
        chk("c_flat", c_flat, exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // Called just after a rising edge; returns just after the accept edge (or later if abort).
  task automatic do_job(input logic [IW-1:0] a, b, input bit acc, input logic [CW-1:0] expv,
                        input bit toggle, input bit abort);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
      return;
    end
    a_flat = a; b_flat = b; acc_en = acc; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(expv);
    acc_q.push_back(cyc);
    held = expv;
    in_valid = 1'b0;
    chki("busy_after_accept", busy, 1);
    if (toggle) begin
      for (int t = 0; t < N; t++) begin
        a_flat = {$urandom, $urandom};
        b_flat = {$urandom, $urandom};
        acc_en = 1'($urandom);
        in_valid = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
    if (abort) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
      held = '0;
      chki("abort_in_ready", in_ready, 1);
      chki("abort_busy", busy, 0);
      chk("abort_c_zero", c_flat, '0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IW-1:0] ra, rb;
    logic [CW-1:0] e;
    bit            racc;
    int            w;
    rst = 1'b1; in_valid = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
    a_flat = '0; b_flat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chki("rst_in_ready", in_ready, 1);
    chki("rst_out_valid", out_valid, 0);
    chki("rst_busy", busy, 0);
    chk("rst_c", c_flat, '0);

    do_job(pk(1,2,3,4), pk(5,6,7,8), 1'b0, pc(19,22,43,50), 1'b0, 1'b0);
    do_job(pk(1,2,3,4), pk(5,6,7,8), 1'b1, pc(38,44,86,100), 1'b0, 1'b0);
    do_job(pk(1,2,3,4), pk(5,6,7,8), 1'b0, pc(19,22,43,50), 1'b1, 1'b0);

    // Hold the result in DONE for five cycles before taking it.
    while (!in_ready) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    do_job(pk(1,2,3,4), pk(5,6,7,8), 1'b1, pc(38,44,86,100), 1'b0, 1'b0);
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_c", c_flat, pc(38,44,86,100));
      chki("stall_out_valid", out_valid, 1);
      chki("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chki("post_hs_in_ready", in_ready, 1);
    chki("post_hs_out_valid", out_valid, 0);

    // Abort mid-compute, then accumulate onto the zeroed C.
    ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
    do_job(ra, rb, 1'b0, model(ra, rb, 1'b0, held), 1'b0, 1'b1);
    do_job(pk(1,0,0,1), pk(1,2,3,4), 1'b1, pc(1,2,3,4), 1'b0, 1'b0);

`ifdef MATMULT_SIGNED_EN
    do_job(pk(-1,0,0,-1), pk(2,3,4,5), 1'b0, pc(-2,-3,-4,-5), 1'b0, 1'b0);
`else
    do_job(pk(-1,0,0,-1), pk(2,3,4,5), 1'b0,
           pc(32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC, 32'h0004FFFB), 1'b0, 1'b0);
`endif

    rnd_rdy = 1'b1;
    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      racc = 1'($urandom);
      e = model(ra, rb, racc, held);
      do_job(ra, rb, racc, e, 1'($urandom), 1'b0);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(posedge clk); #1; w++; end
    chki("drain_pending", exp_q.size(), 0);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matmult_seq.md
MATMULT_SEQ -- requirements
Module: matmult_seq

Interface
REQ-001 Parameter N, default 2: matrix dimension (NxN), legal range 1..8.
REQ-002 Parameter DW, default 16: operand element width.
REQ-003 Parameter AW, default 32: result/accumulator element width; elaboration SHALL fail if AW < 2*DW.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  A/B/acc_en present.
REQ-007 in_ready  output  1  block can accept a job.
REQ-008 acc_en  input  1  when 1, the job adds A*B to the held C instead of overwriting it.
REQ-009 a_flat  input  N*N*DW  A row-major; element (i,j) at bits [(i*N+j)*DW +: DW].
REQ-010 b_flat  input  N*N*DW  B, same packing.
REQ-011 out_valid  output  1  c_flat holds a finished result.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 c_flat  output  N*N*AW  C row-major; element (i,j) at bits [(i*N+j)*AW +: AW].
REQ-014 busy  output  1  high in COMPUTE.

Function
REQ-015 FSM states IDLE, COMPUTE, DONE; in_ready SHALL equal (state==IDLE), out_valid (state==DONE), busy (state==COMPUTE).
REQ-016 IDLE: on in_valid&&in_ready, SHALL register A, B and acc_en, set k=0, clear all C to 0 unless acc_en=1, and go to COMPUTE.
REQ-017 COMPUTE: each cycle SHALL perform C[i][j] += A[i][k]*B[k][j] for all i,j in parallel, then k++; after k=N-1 SHALL go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-019 DONE: c_flat and out_valid SHALL hold stable until out_valid&&out_ready, then go to IDLE; no new job is accepted in that same cycle.
REQ-020 Products SHALL be 2*DW wide, extended to AW, sums wrapping modulo 2^AW; no saturation.
REQ-021 c_flat SHALL retain its last value in IDLE and COMPUTE (intermediate sums visible while busy); consumers SHALL only use it while out_valid=1.
REQ-022 in_valid/a_flat/b_flat/acc_en SHALL be ignored outside IDLE; changes during COMPUTE SHALL NOT affect the result.
REQ-023 N=1: single COMPUTE cycle, out_valid one cycle after accept.

Reset
REQ-024 rst=1 SHALL force state IDLE, k=0, all C, A, B registers to 0, out_valid=0, busy=0, in_ready=1 on the next edge.
REQ-025 Reset during COMPUTE or DONE SHALL abort the job; no out_valid SHALL follow; a subsequent acc_en=1 job accumulates onto zero.

Configuration
REQ-026 Macro MATMULT_SIGNED_EN defined: operands two's-complement signed, products sign-extended to AW.
REQ-027 Macro undefined: operands unsigned, products zero-extended to AW.

Structure
REQ-028 Package matmult_pkg SHALL hold the state enum type and default N/DW/AW constants.
REQ-029 One sub-module matmult_mac_lane (one DW x DW multiply plus AW accumulate register, clear/enable inputs) SHALL be instantiated N*N times by generate.

Verification
REQ-030 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], acc_en=0, out_ready=1 -> out_valid 2 cycles after accept, C=[[19,22],[43,50]].
REQ-031 Repeat same A/B with acc_en=1 -> C=[[38,44],[86,100]].
REQ-032 out_ready held 0 for 5 cycles in DONE -> c_flat/out_valid stable, in_ready=0; handshake on 6th cycle -> IDLE next edge.
REQ-033 rst pulsed in 2nd COMPUTE cycle of N=3 job -> no out_valid; next acc_en=1 job with A=I, B=[[1..9]] -> C=[[1,2,3],[4,5,6],[7,8,9]].
REQ-034 MATMULT_SIGNED_EN, N=2, A=[[-1,0],[0,-1]], B=[[2,3],[4,5]] -> C=[[-2,-3],[-4,-5]] (0xFFFFFFFE...); undefined -> C00=0x0001FFFE.
REQ-035 Inputs toggled randomly during COMPUTE of REQ-030 job -> result still [[19,22],[43,50]].
